rvfi_retire_encoder: RTL and testbench
======================================

Name: rvfi_retire_encoder

Overview:
- Producer side of the RVFI trace interface; converts the core's writeback-stage retire events into one registered RVFI channel (NRET=1).
- Sits between the core pipeline and the formal checkers (hang, liveness, insn, reg checks) in riscv-formal harnesses.
- Owns the retire order counter, sticky halt state, trap-to-intr tracking and zero-register sanitising.
- Output therefore meets RVFI rules by construction.

Parameters:
- XLEN, 32, data/address width.
- ILEN, 32, instruction width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  one instruction retires this cycle.
- wb_insn  in  ILEN  retired instruction word.
- wb_pc  in  XLEN  PC of retired instruction.
- wb_next_pc  in  XLEN  PC of next instruction (trap target if trapped).
- wb_trap  in  1  instruction trapped.
- wb_halt  in  1  core halts after this instruction.
- wb_rs1_addr, wb_rs2_addr  in  5  source register indices.
- wb_rs1_rdata, wb_rs2_rdata  in  XLEN  source operand values.
- wb_rd_addr  in  5  destination index.
- wb_rd_wdata  in  XLEN  destination value.
- wb_mem_addr  in  XLEN  memory address.
- wb_mem_rmask, wb_mem_wmask  in  XLEN/8  byte masks.
- wb_mem_rdata, wb_mem_wdata  in  XLEN  memory data.
- rvfi_valid, rvfi_halt, rvfi_trap, rvfi_intr  out  1  RVFI flags.
- rvfi_order  out  64  retire sequence number.
- rvfi_insn  out  ILEN.
- rvfi_pc_rdata, rvfi_pc_wdata  out  XLEN.
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  5.
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  out  XLEN.
- rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  out  XLEN.
- rvfi_mem_rmask, rvfi_mem_wmask  out  XLEN/8.
- rvfi_mode  out  2  constant 3 (M).
- rvfi_ixl  out  2  constant 1 (32-bit).

Behaviour:
- All rvfi_* outputs are registered; latency is exactly 1 cycle from wb_* to rvfi_*.
- Reset:
  - every rvfi_* output is 0 except mode=3 and ixl=1.
  - order counter=0, pending_intr=0, state=RUN.
  - Reset mid-stream discards the in-flight event; no valid in the cycle after reset.
- State machine:
  - RUN: accepts events.
  - RUN -> HALTED on an accepted event with wb_halt=1; that event is still emitted with rvfi_halt=1.
  - HALTED: rvfi_valid held 0 and wb_* ignored. Exits only via reset.
- Accepted event (wb_valid && RUN):
  - rvfi_valid=1 next cycle with all fields captured.
  - Otherwise rvfi_valid=0 and data fields hold their previous values.
- Order: rvfi_order = counter value at accept; counter increments by 1 per accepted event and wraps modulo 2^64.
- Register sanitising: if rs1_addr==0, rs1_rdata=0 (same for rs2). If rd_addr==0, rd_wdata=0 regardless of input.
- Trap handling:
  - rvfi_trap=wb_trap.
  - When trapped, rd_addr and rd_wdata are 0 and mem_rmask and mem_wmask are 0; mem_addr and data pass through.
- Interrupt/trap entry:
  - An accepted event with wb_trap=1 sets pending_intr.
  - The next accepted event emits rvfi_intr=1 and clears pending_intr.
  - If that event also traps, pending_intr stays set.
- Simultaneous trap+halt: emit trap=1 and halt=1, enter HALTED; pending_intr is irrelevant after that.
- pc_wdata=wb_next_pc unmodified; the block does no PC-continuity checking.

Decomposition:
- Package rvfi_pkg holds:
  - XLEN/ILEN defaults.
  - RVFI_MODE_M=2'd3 and RVFI_IXL_32=2'd1.
  - Encoder state enum {RUN, HALTED}.
- Single flat module; no sub-module is warranted.

Test Plan:
- Three back-to-back accepted events with insns 0x00000013, 0x00100093, 0x00208113 -> rvfi_valid high for 3 cycles starting 1 cycle later; order 0, 1, 2.
- Event with rd_addr=0, rd_wdata=0xDEADBEEF, rs1_addr=0, rs1_rdata=0x55 -> rvfi_rd_wdata=0, rvfi_rs1_rdata=0.
- Trapping event (pc=0x100, next_pc=0x200, rd_addr=5, rmask=0xF), then a normal event at pc=0x200:
  - first output: trap=1, rd_addr=0, rmask=0.
  - second output: intr=1.
  - third output: intr=0.
- Event with wb_halt=1 at order 7, then 4 more wb_valid pulses -> output halt=1 with order 7, then rvfi_valid stays 0.
  - After reset, next event emits order 0.
- Reset asserted in the same cycle as wb_valid -> no rvfi_valid next cycle, all outputs 0 except mode=3 and ixl=1.

Source files
------------

// File: rtl/rvfi_pkg.sv
// Shared definitions for the RVFI retire encoder.
//   RVFI_XLEN / RVFI_ILEN : default data/address and instruction widths
//   RVFI_MODE_M           : privilege mode reported on every retire (machine)
//   RVFI_IXL_32           : XLEN encoding reported on every retire (32-bit)
//   enc_state_e           : encoder run/halt state
package rvfi_pkg;

    localparam int RVFI_XLEN = 32;
    localparam int RVFI_ILEN = 32;

    localparam logic [1:0] RVFI_MODE_M = 2'd3;
    localparam logic [1:0] RVFI_IXL_32 = 2'd1;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } enc_state_e;

endpackage

// File: rtl/rvfi_retire_encoder_if.sv
// Writeback-retire and RVFI channel bundle.
//   wb_*   : retire event from the core's writeback stage
//   rvfi_* : single registered RVFI channel (NRET=1)
// Modports:
//   master : core/harness side, drives wb_*, observes rvfi_*
//   slave  : encoder side, consumes wb_*, drives rvfi_*
interface rvfi_retire_encoder_if
    import rvfi_pkg::*;
#(
    parameter int XLEN = RVFI_XLEN,
    parameter int ILEN = RVFI_ILEN
);
    logic                wb_valid;
    logic [ILEN-1:0]     wb_insn;
    logic [XLEN-1:0]     wb_pc;
    logic [XLEN-1:0]     wb_next_pc;
    logic                wb_trap;
    logic                wb_halt;
    logic [4:0]          wb_rs1_addr;
    logic [4:0]          wb_rs2_addr;
    logic [XLEN-1:0]     wb_rs1_rdata;
    logic [XLEN-1:0]     wb_rs2_rdata;
    logic [4:0]          wb_rd_addr;
    logic [XLEN-1:0]     wb_rd_wdata;
    logic [XLEN-1:0]     wb_mem_addr;
    logic [XLEN/8-1:0]   wb_mem_rmask;
    logic [XLEN/8-1:0]   wb_mem_wmask;
    logic [XLEN-1:0]     wb_mem_rdata;
    logic [XLEN-1:0]     wb_mem_wdata;

    logic                rvfi_valid;
    logic                rvfi_halt;
    logic                rvfi_trap;
    logic                rvfi_intr;
    logic [63:0]         rvfi_order;
    logic [ILEN-1:0]     rvfi_insn;
    logic [XLEN-1:0]     rvfi_pc_rdata;
    logic [XLEN-1:0]     rvfi_pc_wdata;
    logic [4:0]          rvfi_rs1_addr;
    logic [4:0]          rvfi_rs2_addr;
    logic [4:0]          rvfi_rd_addr;
    logic [XLEN-1:0]     rvfi_rs1_rdata;
    logic [XLEN-1:0]     rvfi_rs2_rdata;
    logic [XLEN-1:0]     rvfi_rd_wdata;
    logic [XLEN-1:0]     rvfi_mem_addr;
    logic [XLEN-1:0]     rvfi_mem_rdata;
    logic [XLEN-1:0]     rvfi_mem_wdata;
    logic [XLEN/8-1:0]   rvfi_mem_rmask;
    logic [XLEN/8-1:0]   rvfi_mem_wmask;
    logic [1:0]          rvfi_mode;
    logic [1:0]          rvfi_ixl;

    modport master (
        output wb_valid, wb_insn, wb_pc, wb_next_pc, wb_trap, wb_halt,
               wb_rs1_addr, wb_rs2_addr, wb_rs1_rdata, wb_rs2_rdata,
               wb_rd_addr, wb_rd_wdata, wb_mem_addr, wb_mem_rmask,
               wb_mem_wmask, wb_mem_rdata, wb_mem_wdata,
        input  rvfi_valid, rvfi_halt, rvfi_trap, rvfi_intr, rvfi_order,
               rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr,
               rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
               rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mode, rvfi_ixl
    );

    modport slave (
        input  wb_valid, wb_insn, wb_pc, wb_next_pc, wb_trap, wb_halt,
               wb_rs1_addr, wb_rs2_addr, wb_rs1_rdata, wb_rs2_rdata,
               wb_rd_addr, wb_rd_wdata, wb_mem_addr, wb_mem_rmask,
               wb_mem_wmask, wb_mem_rdata, wb_mem_wdata,
        output rvfi_valid, rvfi_halt, rvfi_trap, rvfi_intr, rvfi_order,
               rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr,
               rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
               rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mode, rvfi_ixl
    );

endinterface

// File: rtl/rvfi_retire_encoder.sv
// RVFI retire encoder: turns writeback retire events into one registered
// RVFI channel with exactly one cycle of latency.
// Ports:
//   clock : single clock
//   reset : synchronous, active-high
//   bus   : rvfi_retire_encoder_if.slave (wb_* in, rvfi_* out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | accepting retire events
// HALTED | a halting instruction retired; wb_* ignored until reset
module rvfi_retire_encoder
    import rvfi_pkg::*;
#(
    parameter int XLEN = RVFI_XLEN,
    parameter int ILEN = RVFI_ILEN
) (
    input  logic                  clock,
    input  logic                  reset,
    rvfi_retire_encoder_if.slave  bus
);

    enc_state_e  state;
    logic [63:0] order_cnt;
    logic        pending_intr;
    logic        accept;

    assign accept = bus.wb_valid && (state == RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= RUN;
            order_cnt          <= '0;
            pending_intr       <= 1'b0;
            bus.rvfi_valid     <= 1'b0;
            bus.rvfi_halt      <= 1'b0;
            bus.rvfi_trap      <= 1'b0;
            bus.rvfi_intr      <= 1'b0;
            bus.rvfi_order     <= '0;
            bus.rvfi_insn      <= '0;
            bus.rvfi_pc_rdata  <= '0;
            bus.rvfi_pc_wdata  <= '0;
            bus.rvfi_rs1_addr  <= '0;
            bus.rvfi_rs2_addr  <= '0;
            bus.rvfi_rd_addr   <= '0;
            bus.rvfi_rs1_rdata <= '0;
            bus.rvfi_rs2_rdata <= '0;
            bus.rvfi_rd_wdata  <= '0;
            bus.rvfi_mem_addr  <= '0;
            bus.rvfi_mem_rdata <= '0;
            bus.rvfi_mem_wdata <= '0;
            bus.rvfi_mem_rmask <= '0;
            bus.rvfi_mem_wmask <= '0;
            bus.rvfi_mode      <= RVFI_MODE_M;
            bus.rvfi_ixl       <= RVFI_IXL_32;
        end else begin
            bus.rvfi_valid <= accept;
            bus.rvfi_mode  <= RVFI_MODE_M;
            bus.rvfi_ixl   <= RVFI_IXL_32;
            if (accept) begin
                bus.rvfi_halt      <= bus.wb_halt;
                bus.rvfi_trap      <= bus.wb_trap;
                bus.rvfi_intr      <= pending_intr;
                bus.rvfi_order     <= order_cnt;
                bus.rvfi_insn      <= bus.wb_insn;
                bus.rvfi_pc_rdata  <= bus.wb_pc;
                bus.rvfi_pc_wdata  <= bus.wb_next_pc;
                bus.rvfi_rs1_addr  <= bus.wb_rs1_addr;
                bus.rvfi_rs2_addr  <= bus.wb_rs2_addr;
                bus.rvfi_rs1_rdata <= (bus.wb_rs1_addr == 5'd0) ? '0 : bus.wb_rs1_rdata;
                bus.rvfi_rs2_rdata <= (bus.wb_rs2_addr == 5'd0) ? '0 : bus.wb_rs2_rdata;
                // A trapped instruction commits no register or memory side effects.
                bus.rvfi_rd_addr   <= bus.wb_trap ? 5'd0 : bus.wb_rd_addr;
                bus.rvfi_rd_wdata  <= (bus.wb_trap || bus.wb_rd_addr == 5'd0) ? '0 : bus.wb_rd_wdata;
                bus.rvfi_mem_addr  <= bus.wb_mem_addr;
                bus.rvfi_mem_rdata <= bus.wb_mem_rdata;
                bus.rvfi_mem_wdata <= bus.wb_mem_wdata;
                bus.rvfi_mem_rmask <= bus.wb_trap ? '0 : bus.wb_mem_rmask;
                bus.rvfi_mem_wmask <= bus.wb_trap ? '0 : bus.wb_mem_wmask;
                order_cnt          <= order_cnt + 64'd1;
                // The instruction after a trap is the handler entry: flag it as intr.
                // A trapping handler entry re-arms the flag for its own successor.
                pending_intr       <= bus.wb_trap;
                if (bus.wb_halt) begin
                    state <= HALTED;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_encoder.sv
module tb_rvfi_retire_encoder;
    import rvfi_pkg::*;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rvfi_retire_encoder_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    rvfi_retire_encoder #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: what the RVFI channel should show after each edge.
    typedef struct packed {
        logic        valid, halt, trap, intr;
        logic [63:0] order;
        logic [31:0] insn, pc_r, pc_w, rs1_d, rs2_d, rd_d, maddr, mrd, mwd;
        logic [4:0]  rs1_a, rs2_a, rd_a;
        logic [3:0]  rm, wm;
    } rec_t;

    rec_t            e;
    longint unsigned m_retired;   // instructions retired since reset
    bit              m_after_trap;
    bit              m_stopped;

    task automatic model_step();
        if (reset) begin
            e = '0;
            m_retired = 0;
            m_after_trap = 0;
            m_stopped = 0;
            return;
        end
        e.valid = bus.wb_valid && !m_stopped;
        if (!e.valid) return;
        e.halt  = bus.wb_halt;
        e.trap  = bus.wb_trap;
        e.intr  = m_after_trap;
        e.order = m_retired;
        e.insn  = bus.wb_insn;
        e.pc_r  = bus.wb_pc;
        e.pc_w  = bus.wb_next_pc;
        e.rs1_a = bus.wb_rs1_addr;
        e.rs2_a = bus.wb_rs2_addr;
        e.rs1_d = (bus.wb_rs1_addr == 0) ? 32'd0 : bus.wb_rs1_rdata;
        e.rs2_d = (bus.wb_rs2_addr == 0) ? 32'd0 : bus.wb_rs2_rdata;
        if (bus.wb_trap) begin
            e.rd_a = 0; e.rd_d = 0; e.rm = 0; e.wm = 0;
        end else begin
            e.rd_a = bus.wb_rd_addr;
            e.rd_d = (bus.wb_rd_addr == 0) ? 32'd0 : bus.wb_rd_wdata;
            e.rm   = bus.wb_mem_rmask;
            e.wm   = bus.wb_mem_wmask;
        end
        e.maddr = bus.wb_mem_addr;
        e.mrd   = bus.wb_mem_rdata;
        e.mwd   = bus.wb_mem_wdata;
        m_retired = m_retired + 1;
        m_after_trap = bus.wb_trap;
        if (bus.wb_halt) m_stopped = 1;
    endtask

    task automatic compare_all();
        chk("valid", bus.rvfi_valid, e.valid);
        chk("halt", bus.rvfi_halt, e.halt);
        chk("trap", bus.rvfi_trap, e.trap);
        chk("intr", bus.rvfi_intr, e.intr);
        chk("order", bus.rvfi_order, e.order);
        chk("insn", bus.rvfi_insn, e.insn);
        chk("pc_rdata", bus.rvfi_pc_rdata, e.pc_r);
        chk("pc_wdata", bus.rvfi_pc_wdata, e.pc_w);
        chk("rs1_addr", bus.rvfi_rs1_addr, e.rs1_a);
        chk("rs2_addr", bus.rvfi_rs2_addr, e.rs2_a);
        chk("rs1_rdata", bus.rvfi_rs1_rdata, e.rs1_d);
        chk("rs2_rdata", bus.rvfi_rs2_rdata, e.rs2_d);
        chk("rd_addr", bus.rvfi_rd_addr, e.rd_a);
        chk("rd_wdata", bus.rvfi_rd_wdata, e.rd_d);
        chk("mem_addr", bus.rvfi_mem_addr, e.maddr);
        chk("mem_rdata", bus.rvfi_mem_rdata, e.mrd);
        chk("mem_wdata", bus.rvfi_mem_wdata, e.mwd);
        chk("mem_rmask", bus.rvfi_mem_rmask, e.rm);
        chk("mem_wmask", bus.rvfi_mem_wmask, e.wm);
        chk("mode", bus.rvfi_mode, 2'd3);
        chk("ixl", bus.rvfi_ixl, 2'd1);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_step();
        compare_all();
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    task automatic rand_ev(input logic valid);
        bus.wb_valid     = valid;
        bus.wb_insn      = $urandom;
        bus.wb_pc        = $urandom & 32'hFFFF_FFFC;
        bus.wb_next_pc   = $urandom & 32'hFFFF_FFFC;
        bus.wb_trap      = 1'b0;
        bus.wb_halt      = 1'b0;
        bus.wb_rs1_addr  = rand_reg();
        bus.wb_rs2_addr  = rand_reg();
        bus.wb_rs1_rdata = $urandom;
        bus.wb_rs2_rdata = $urandom;
        bus.wb_rd_addr   = rand_reg();
        bus.wb_rd_wdata  = $urandom;
        bus.wb_mem_addr  = $urandom;
        bus.wb_mem_rmask = 4'($urandom);
        bus.wb_mem_wmask = 4'($urandom);
        bus.wb_mem_rdata = $urandom;
        bus.wb_mem_wdata = $urandom;
    endtask

    logic [31:0] tp_insn [3];

    initial begin
        tp_insn[0] = 32'h0000_0013;
        tp_insn[1] = 32'h0010_0093;
        tp_insn[2] = 32'h0020_8113;

        rand_ev(1'b0);
        reset = 1'b1;
        step();
        step();
        chk("reset_valid", bus.rvfi_valid, 1'b0);
        chk("reset_mode", bus.rvfi_mode, RVFI_MODE_M);
        chk("reset_order", bus.rvfi_order, 64'd0);
        reset = 1'b0;
        rand_ev(1'b0);
        step();

        // Three back-to-back retires
        for (int i = 0; i < 3; i++) begin
            rand_ev(1'b1);
            bus.wb_insn = tp_insn[i];
            step();
            chk("b2b_valid", bus.rvfi_valid, 1'b1);
            chk("b2b_order", bus.rvfi_order, 64'(i));
            chk("b2b_insn", bus.rvfi_insn, tp_insn[i]);
        end
        rand_ev(1'b0);
        step();
        chk("b2b_idle", bus.rvfi_valid, 1'b0);

        // x0 sanitising
        rand_ev(1'b1);
        bus.wb_rd_addr = 5'd0;  bus.wb_rd_wdata = 32'hDEAD_BEEF;
        bus.wb_rs1_addr = 5'd0; bus.wb_rs1_rdata = 32'h55;
        step();
        chk("x0_rd_wdata", bus.rvfi_rd_wdata, 32'd0);
        chk("x0_rs1_rdata", bus.rvfi_rs1_rdata, 32'd0);

        // Trap, then handler entry, then ordinary instruction
        rand_ev(1'b1);
        bus.wb_trap = 1'b1; bus.wb_pc = 32'h100; bus.wb_next_pc = 32'h200;
        bus.wb_rd_addr = 5'd5; bus.wb_mem_rmask = 4'hF;
        step();
        chk("trap_flag", bus.rvfi_trap, 1'b1);
        chk("trap_rd_addr", bus.rvfi_rd_addr, 5'd0);
        chk("trap_rmask", bus.rvfi_mem_rmask, 4'h0);
        chk("trap_pc_wdata", bus.rvfi_pc_wdata, 32'h200);
        rand_ev(1'b1);
        bus.wb_pc = 32'h200;
        step();
        chk("handler_intr", bus.rvfi_intr, 1'b1);
        rand_ev(1'b1);
        step();
        chk("after_intr", bus.rvfi_intr, 1'b0);

        // Halt at order 7, then further retires are ignored
        reset = 1'b1; rand_ev(1'b0); step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_ev(1'b1);
            step();
        end
        rand_ev(1'b1);
        bus.wb_halt = 1'b1;
        step();
        chk("halt_flag", bus.rvfi_halt, 1'b1);
        chk("halt_order", bus.rvfi_order, 64'd7);
        for (int i = 0; i < 4; i++) begin
            rand_ev(1'b1);
            step();
            chk("halted_valid", bus.rvfi_valid, 1'b0);
        end
        reset = 1'b1; rand_ev(1'b0); step();
        reset = 1'b0; rand_ev(1'b1); step();
        chk("post_halt_order", bus.rvfi_order, 64'd0);
        chk("post_halt_valid", bus.rvfi_valid, 1'b1);

        // Reset coinciding with a retire
        rand_ev(1'b1);
        reset = 1'b1;
        step();
        chk("rst_ev_valid", bus.rvfi_valid, 1'b0);
        chk("rst_ev_insn", bus.rvfi_insn, 32'd0);
        chk("rst_ev_ixl", bus.rvfi_ixl, RVFI_IXL_32);
        reset = 1'b0;

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            rand_ev($urandom_range(0, 9) < 7);
            bus.wb_trap = ($urandom_range(0, 4) == 0);
            bus.wb_halt = ($urandom_range(0, 59) == 0);
            reset       = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
